// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/opcode request channel and result/flags response
// channel of seq_alu, each with its own valid/ready pair.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [3:0]         sel;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               zero;
  logic               carry;
  logic               err;

  // sequencer / producer side
  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, result, zero, carry, err
  );

  // ALU side
  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, result, zero, carry, err
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: handshaked WIDTH-bit ALU. Logic/add/shift ops finish in one cycle;
// MUL (shift-add) and DIV/MOD (restoring) iterate WIDTH cycles.
// Build option: SEQ_ALU_DIV_EN compiles in the iterative divider; without it
// DIV/MOD are reported as unsupported opcodes.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input logic   clk,
  input logic   rst,
  seq_alu_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_MOD = 4'b1010;
  localparam logic [3:0] OP_EQ  = 4'b1011;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   op_a;
  // MUL: acc_hi = product high half, acc_lo = multiplier shifting into product low half
  // DIV: acc_hi = partial remainder,  acc_lo = dividend shifting out / quotient in
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [2*WIDTH-1:0] res_q;
  logic               zero_q;
  logic               carry_q;
  logic               err_q;
`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH-1:0]   op_b;
  logic [3:0]         op_sel;
  logic [WIDTH:0]     div_t;
  logic [WIDTH:0]     div_d;
  logic               div_ge;
`endif

  // single-cycle result decode straight from the request channel
  logic [2*WIDTH-1:0] q_res;
  logic               q_carry;
  logic               q_err;
  logic               q_iter;

  // one iteration step of the multiplier / divider
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   nxt_hi;
  logic [WIDTH-1:0]   nxt_lo;
  logic [2*WIDTH-1:0] it_res;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.err       = err_q;

  // decode the opcode; iterative ops only flag q_iter, zero operand b short-circuits them
  always_comb begin
    q_res   = '0;
    q_carry = 1'b0;
    q_err   = 1'b0;
    q_iter  = 1'b0;
    case (bus.sel)
      OP_ADD: begin
        q_res[WIDTH:0] = {1'b0, bus.a} + {1'b0, bus.b};
        q_carry        = q_res[WIDTH];
      end
      OP_SUB: begin
        q_res[WIDTH-1:0] = bus.a - bus.b;
        q_carry          = (bus.a < bus.b);
      end
      OP_AND: q_res[WIDTH-1:0] = bus.a & bus.b;
      OP_OR:  q_res[WIDTH-1:0] = bus.a | bus.b;
      OP_XOR: q_res[WIDTH-1:0] = bus.a ^ bus.b;
      OP_NOT: q_res[WIDTH-1:0] = ~bus.a;
      OP_SHL: begin
        q_res[WIDTH:0] = {bus.a, 1'b0};
        q_carry        = bus.a[WIDTH-1];
      end
      OP_SHR: q_res[WIDTH-1:0] = bus.a >> 1;
      // multiply by zero is trivially zero, no need to iterate
      OP_MUL: q_iter = (bus.b != '0);
`ifdef SEQ_ALU_DIV_EN
      OP_DIV, OP_MOD: begin
        if (bus.b == '0) q_err  = 1'b1;
        else             q_iter = 1'b1;
      end
`endif
      OP_EQ:  q_res[0] = (bus.a == bus.b);
      default: q_err = 1'b1;
    endcase
  end

  // next accumulator values; it_res is the final answer on the last step
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_a} : {(WIDTH+1){1'b0}});
    nxt_hi  = mul_sum[WIDTH:1];
    nxt_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};
    it_res  = {nxt_hi, nxt_lo};
`ifdef SEQ_ALU_DIV_EN
    div_t  = {acc_hi, acc_lo[WIDTH-1]};
    div_d  = div_t - {1'b0, op_b};
    div_ge = (div_t >= {1'b0, op_b});
    if (op_sel != OP_MUL) begin
      nxt_hi = div_ge ? div_d[WIDTH-1:0] : div_t[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
      it_res = (op_sel == OP_DIV) ? {{WIDTH{1'b0}}, nxt_lo} : {{WIDTH{1'b0}}, nxt_hi};
    end
`endif
  end

  // IDLE/BUSY/DONE control, operand capture, iteration and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_a    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      op_b    <= '0;
      op_sel  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (q_iter) begin
              state  <= BUSY;
              cnt    <= '0;
              op_a   <= bus.a;
              acc_hi <= '0;
`ifdef SEQ_ALU_DIV_EN
              op_b   <= bus.b;
              op_sel <= bus.sel;
              acc_lo <= (bus.sel == OP_MUL) ? bus.b : bus.a;
`else
              acc_lo <= bus.b;
`endif
            end else begin
              state   <= DONE;
              res_q   <= q_res;
              zero_q  <= (q_res == '0);
              carry_q <= q_carry;
              err_q   <= q_err;
            end
          end
        end
        BUSY: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
            state   <= DONE;
            res_q   <= it_res;
            zero_q  <= (it_res == '0);
            carry_q <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed-vector bench for seq_alu at WIDTH=8.
// Honours SEQ_ALU_DIV_EN for the DIV/MOD expectations.
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(8)) bus ();
  seq_alu #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  // present one request and return 1ns after the accepting edge
  task automatic issue(input logic [3:0] s, input logic [7:0] x, input logic [7:0] y);
    bus.sel = s; bus.a = x; bus.b = y; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // complete the output handshake
  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %0d want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %0d want 0", bus.out_valid); end
    n_cmp++; if (bus.result !== 16'd0) begin n_bad++; $display("FAIL rst_result: got %0d want 0", bus.result); end
    n_cmp++; if ({bus.zero, bus.carry, bus.err} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {bus.zero, bus.carry, bus.err}); end
    @(posedge clk); #1; rst = 1'b0;
    issue(4'b0000, 8'd1, 8'd1);
    drain();
    // MUL 200*3, abort four cycles in
    issue(4'b1000, 8'd200, 8'd3);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_in_ready: got %0d want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_out_valid: got %0d want 0", bus.out_valid); end
    n_cmp++; if (bus.result !== 16'd0) begin n_bad++; $display("FAIL abort_result: got %0d want 0", bus.result); end
    @(posedge clk); #1; rst = 1'b0;
    issue(4'b0000, 8'd1, 8'd1);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.result !== 16'd2) begin n_bad++; $display("FAIL post_rst_add: got v=%0d r=%0d want v=1 r=2", bus.out_valid, bus.result); end
    drain();
  endtask

  task automatic test_add_sub();
    issue(4'b0000, 8'd255, 8'd1);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL add_latency: got %0d want 1", bus.out_valid); end
    n_cmp++; if (bus.result !== 16'd256) begin n_bad++; $display("FAIL add_result: got %0d want 256", bus.result); end
    n_cmp++; if (bus.carry !== 1'b1 || bus.zero !== 1'b0) begin n_bad++; $display("FAIL add_flags: got c=%0d z=%0d want c=1 z=0", bus.carry, bus.zero); end
    drain();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL add_drain: got v=%0d rdy=%0d want v=0 rdy=1", bus.out_valid, bus.in_ready); end
    issue(4'b0001, 8'd3, 8'd5);
    n_cmp++; if (bus.result !== 16'd254 || bus.carry !== 1'b1) begin n_bad++; $display("FAIL sub_result: got r=%0d c=%0d want r=254 c=1", bus.result, bus.carry); end
    drain();
    issue(4'b0110, 8'hC1, 8'd0);
    n_cmp++; if (bus.result !== 16'h182 || bus.carry !== 1'b1) begin n_bad++; $display("FAIL shl_result: got r=%0h c=%0d want r=182 c=1", bus.result, bus.carry); end
    drain();
  endtask

  task automatic test_mul();
    issue(4'b1000, 8'd255, 8'd255);
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL mul_busy_c1: got v=%0d rdy=%0d want v=0 rdy=0", bus.out_valid, bus.in_ready); end
    for (int i = 2; i <= 8; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL mul_busy_c%0d: got v=%0d rdy=%0d want v=0 rdy=0", i, bus.out_valid, bus.in_ready); end
    end
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL mul_latency: got %0d want 1 at cycle 9", bus.out_valid); end
    n_cmp++; if (bus.result !== 16'd65025) begin n_bad++; $display("FAIL mul_result: got %0d want 65025", bus.result); end
    drain();
  endtask

  task automatic test_div();
`ifdef SEQ_ALU_DIV_EN
    issue(4'b1001, 8'd200, 8'd7);
    repeat (8) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.result !== 16'd28 || bus.err !== 1'b0) begin n_bad++; $display("FAIL div_result: got v=%0d r=%0d e=%0d want v=1 r=28 e=0", bus.out_valid, bus.result, bus.err); end
    drain();
    issue(4'b1010, 8'd200, 8'd7);
    repeat (8) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.result !== 16'd4) begin n_bad++; $display("FAIL mod_result: got v=%0d r=%0d want v=1 r=4", bus.out_valid, bus.result); end
    drain();
`else
    issue(4'b1001, 8'd200, 8'd7);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.result !== 16'd0 || bus.err !== 1'b1) begin n_bad++; $display("FAIL div_disabled: got v=%0d r=%0d e=%0d want v=1 r=0 e=1", bus.out_valid, bus.result, bus.err); end
    drain();
`endif
    issue(4'b1001, 8'd9, 8'd0);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.result !== 16'd0) begin n_bad++; $display("FAIL div0_result: got v=%0d r=%0d want v=1 r=0", bus.out_valid, bus.result); end
    n_cmp++; if (bus.err !== 1'b1 || bus.zero !== 1'b1) begin n_bad++; $display("FAIL div0_flags: got e=%0d z=%0d want e=1 z=1", bus.err, bus.zero); end
    drain();
  endtask

  task automatic test_backpressure();
    issue(4'b1011, 8'd17, 8'd17);
    // a competing ADD 2+3 waits on the request channel during the stall
    bus.sel = 4'b0000; bus.a = 8'd2; bus.b = 8'd3; bus.in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.result !== 16'd1 || bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_c%0d: got v=%0d r=%0d rdy=%0d want v=1 r=1 rdy=0", i, bus.out_valid, bus.result, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release: got v=%0d rdy=%0d want v=0 rdy=1", bus.out_valid, bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.result !== 16'd5) begin n_bad++; $display("FAIL stall_next_op: got v=%0d r=%0d want v=1 r=5", bus.out_valid, bus.result); end
    drain();
  endtask

  task automatic test_misc();
    issue(4'b1111, 8'd5, 8'd0);
    n_cmp++; if (bus.result !== 16'd0 || bus.err !== 1'b1 || bus.zero !== 1'b1) begin n_bad++; $display("FAIL bad_op: got r=%0d e=%0d z=%0d want r=0 e=1 z=1", bus.result, bus.err, bus.zero); end
    drain();
    issue(4'b0101, 8'h0F, 8'd0);
    n_cmp++; if (bus.result !== 16'h00F0 || bus.err !== 1'b0) begin n_bad++; $display("FAIL not_op: got r=%0h e=%0d want r=f0 e=0", bus.result, bus.err); end
    drain();
    issue(4'b1011, 8'd17, 8'd18);
    n_cmp++; if (bus.result !== 16'd0 || bus.zero !== 1'b1) begin n_bad++; $display("FAIL eq_false: got r=%0d z=%0d want r=0 z=1", bus.result, bus.zero); end
    drain();
  endtask

  task automatic test_back_to_back();
    // out_ready held high: each op spends exactly one cycle in DONE
    bus.out_ready = 1'b1;
    issue(4'b0010, 8'hF0, 8'h3C);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.result !== 16'h0030) begin n_bad++; $display("FAIL b2b_and: got v=%0d r=%0h want v=1 r=30", bus.out_valid, bus.result); end
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_done_len: got v=%0d rdy=%0d want v=0 rdy=1", bus.out_valid, bus.in_ready); end
    issue(4'b0111, 8'h81, 8'd0);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.result !== 16'h0040 || bus.carry !== 1'b0) begin n_bad++; $display("FAIL b2b_shr: got v=%0d r=%0h c=%0d want v=1 r=40 c=0", bus.out_valid, bus.result, bus.carry); end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sel = '0; bus.out_ready = 1'b0;
    #12;
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_backpressure();
    test_misc();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
